// File: rtl/mips_ctrl_pkg.sv
// Purpose: shared opcodes, FSM state encoding and control-word layout for the multi-cycle MIPS controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

   // Supported instruction opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operation selects
   localparam logic [1:0] ALUOP_ADD   = 2'b11;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b00;

   // ALU B-operand selects
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // Next-PC source selects
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   // Datapath control word produced by the state decoder
   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memToReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSrc;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purpose: maps the current FSM state to the raw datapath control word (no handshake gating).
// Latency: purely combinational, zero cycles.
// Backpressure: none; memory-ready gating of FETCH strobes is applied by the caller.
module multicycle_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t curState,
   output ctrl_t  ctrl
);

   // Moore decode: every unlisted field stays 0, unused encodings give an all-zero word
   always_comb begin
      ctrl = '0;
      case (curState)
         FETCH: begin
            ctrl.memRead = 1'b1;
            ctrl.irWrite = 1'b1;
            ctrl.pcWrite = 1'b1;
            ctrl.aluSrcB = SRCB_FOUR;
            ctrl.aluOp   = ALUOP_ADD;
            ctrl.pcSrc   = PCSRC_ALU;
         end
         DECODE: begin
            // branch target is precomputed here so BEQEX only needs the compare
            ctrl.aluSrcB = SRCB_IMMSH;
            ctrl.aluOp   = ALUOP_ADD;
         end
         MEMADR, ADDIEX: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALUOP_ADD;
         end
         MEMRD: begin
            ctrl.iorD    = 1'b1;
            ctrl.memRead = 1'b1;
         end
         MEMWB: begin
            ctrl.memToReg = 1'b1;
            ctrl.regWrite = 1'b1;
         end
         MEMWR: begin
            ctrl.iorD     = 1'b1;
            ctrl.memWrite = 1'b1;
         end
         RTYPEEX: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_REG;
            ctrl.aluOp   = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            ctrl.regDst   = 1'b1;
            ctrl.regWrite = 1'b1;
         end
         BEQEX: begin
            ctrl.aluSrcA     = 1'b1;
            ctrl.aluSrcB     = SRCB_REG;
            ctrl.aluOp       = ALUOP_SUB;
            ctrl.pcSrc       = PCSRC_ALUOUT;
            ctrl.pcWriteCond = 1'b1;
         end
         ADDIWB: begin
            ctrl.regWrite = 1'b1;
         end
         JEX: begin
            ctrl.pcSrc   = PCSRC_JUMP;
            ctrl.pcWrite = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Purpose: multi-cycle MIPS main control FSM with retired-instruction counter and illegal-opcode pulse.
// Latency: 3-5 cycles per instruction with zero wait states; outputs follow state combinationally.
// Backpressure: FETCH, MEMRD and MEMWR hold until memReady (ignored when MEM_HANDSHAKE=0).
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W          = 6,
   parameter int MEM_HANDSHAKE = 1,
   parameter int CNT_W         = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [OP_W-1:0]  opcode,
   input  logic             memReady,
   output logic             pcWrite,
   output logic             pcWriteCond,
   output logic             iorD,
   output logic             memRead,
   output logic             memWrite,
   output logic             irWrite,
   output logic             memToReg,
   output logic             regDst,
   output logic             regWrite,
   output logic             aluSrcA,
   output logic [1:0]       aluSrcB,
   output logic [1:0]       aluOp,
   output logic [1:0]       pcSrc,
   output logic             illegalOp,
   output logic [CNT_W-1:0] instrRetired,
   output logic [3:0]       state
);

   localparam logic [OP_W-1:0] RTYPE_OP = OP_W'(OP_RTYPE);
   localparam logic [OP_W-1:0] LW_OP    = OP_W'(OP_LW);
   localparam logic [OP_W-1:0] SW_OP    = OP_W'(OP_SW);
   localparam logic [OP_W-1:0] BEQ_OP   = OP_W'(OP_BEQ);
   localparam logic [OP_W-1:0] ADDI_OP  = OP_W'(OP_ADDI);
   localparam logic [OP_W-1:0] J_OP     = OP_W'(OP_J);

   state_t curState;
   state_t nextState;
   ctrl_t  rawCtrl;
   ctrl_t  outCtrl;
   logic   memRdy;
   logic   retire;
   logic   badOp;

   assign memRdy = (MEM_HANDSHAKE != 0) ? memReady : 1'b1;

   multicycle_ctrl_decode u_decode (
      .curState (curState),
      .ctrl     (rawCtrl)
   );

   // Next-state selection, retire detection and opcode legality check
   always_comb begin
      nextState = FETCH;
      retire    = 1'b0;
      badOp     = 1'b0;
      case (curState)
         FETCH:   nextState = memRdy ? DECODE : FETCH;
         DECODE: begin
            if (opcode == LW_OP || opcode == SW_OP) nextState = MEMADR;
            else if (opcode == RTYPE_OP)            nextState = RTYPEEX;
            else if (opcode == BEQ_OP)              nextState = BEQEX;
            else if (opcode == ADDI_OP)             nextState = ADDIEX;
            else if (opcode == J_OP)                nextState = JEX;
            else                                    badOp     = 1'b1;
         end
         MEMADR:  nextState = (opcode == LW_OP) ? MEMRD : MEMWR;
         MEMRD:   nextState = memRdy ? MEMWB : MEMRD;
         MEMWR: begin
            // the store retires on the cycle memory accepts it
            nextState = memRdy ? FETCH : MEMWR;
            retire    = memRdy;
         end
         RTYPEEX: nextState = RTYPEWB;
         ADDIEX:  nextState = ADDIWB;
         MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX: retire = 1'b1;
         default: nextState = FETCH;
      endcase
   end

   // State register and retired-instruction counter; reset abandons any instruction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         curState     <= FETCH;
         instrRetired <= '0;
      end else begin
         curState <= nextState;
         if (retire) instrRetired <= instrRetired + CNT_W'(1);
      end
   end

   // FETCH strobes wait for memory so IR/PC load exactly once; reset kills every output
   always_comb begin
      outCtrl   = rawCtrl;
      illegalOp = 1'b0;
      if (curState == FETCH) begin
         outCtrl.irWrite = rawCtrl.irWrite & memRdy;
         outCtrl.pcWrite = rawCtrl.pcWrite & memRdy;
      end
      if (curState == DECODE) illegalOp = badOp;
      if (reset) begin
         outCtrl   = '0;
         illegalOp = 1'b0;
      end
   end

   assign pcWrite     = outCtrl.pcWrite;
   assign pcWriteCond = outCtrl.pcWriteCond;
   assign iorD        = outCtrl.iorD;
   assign memRead     = outCtrl.memRead;
   assign memWrite    = outCtrl.memWrite;
   assign irWrite     = outCtrl.irWrite;
   assign memToReg    = outCtrl.memToReg;
   assign regDst      = outCtrl.regDst;
   assign regWrite    = outCtrl.regWrite;
   assign aluSrcA     = outCtrl.aluSrcA;
   assign aluSrcB     = outCtrl.aluSrcB;
   assign aluOp       = outCtrl.aluOp;
   assign pcSrc       = outCtrl.pcSrc;
   assign state       = curState;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: self-checking bench for multicycle_control using a per-cycle vector table plus wrap/no-handshake sequences.
// Latency: one vector per clock; outputs sampled 1 time unit after the falling edge.
// Backpressure: memReady driven from the vector table; one instance ties it low with the handshake disabled.
module tb_multicycle_control;

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_ADDI = 6'b001000;
   localparam logic [5:0] OPC_J    = 6'b000010;
   localparam logic [5:0] OPC_BAD  = 6'b111111;

   // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,regWrite,aluSrcA}_aluSrcB_aluOp_pcSrc_illegalOp
   localparam logic [16:0] E_ZERO   = 17'b0000000000_00_00_00_0;
   localparam logic [16:0] E_FETCH  = 17'b1001010000_01_11_00_0;
   localparam logic [16:0] E_FWAIT  = 17'b0001000000_01_11_00_0;
   localparam logic [16:0] E_DEC    = 17'b0000000000_11_11_00_0;
   localparam logic [16:0] E_DECILL = 17'b0000000000_11_11_00_1;
   localparam logic [16:0] E_MEMADR = 17'b0000000001_10_11_00_0;
   localparam logic [16:0] E_MEMRD  = 17'b0011000000_00_00_00_0;
   localparam logic [16:0] E_MEMWB  = 17'b0000001010_00_00_00_0;
   localparam logic [16:0] E_MEMWR  = 17'b0010100000_00_00_00_0;
   localparam logic [16:0] E_RTEX   = 17'b0000000001_00_00_00_0;
   localparam logic [16:0] E_RTWB   = 17'b0000000110_00_00_00_0;
   localparam logic [16:0] E_BEQ    = 17'b0100000001_00_01_01_0;
   localparam logic [16:0] E_ADDIEX = 17'b0000000001_10_11_00_0;
   localparam logic [16:0] E_ADDIWB = 17'b0000000010_00_00_00_0;
   localparam logic [16:0] E_JEX    = 17'b1000000000_00_00_10_0;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [16:0] ctl;
      logic [31:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic        reset, memReady;
   logic [5:0]  opcode;
   logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic        memToReg, regDst, regWrite, aluSrcA, illegalOp;
   logic [1:0]  aluSrcB, aluOp, pcSrc;
   logic [31:0] instrRetired;
   logic [3:0]  state;
   logic [16:0] ctl;

   assign ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                 regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, illegalOp};

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
      .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
      .pcSrc(pcSrc), .illegalOp(illegalOp), .instrRetired(instrRetired), .state(state)
   );

   // narrow-counter instance for wrap checking
   logic        wReset;
   logic [5:0]  wOp;
   logic        wPcWrite, wPcWriteCond, wIorD, wMemRead, wMemWrite, wIrWrite;
   logic        wMemToReg, wRegDst, wRegWrite, wAluSrcA, wIllegalOp;
   logic [1:0]  wAluSrcB, wAluOp, wPcSrc;
   logic [3:0]  wCnt;
   logic [3:0]  wState;

   multicycle_control #(.CNT_W(4)) dutWrap (
      .clk(clk), .reset(wReset), .opcode(wOp), .memReady(1'b1),
      .pcWrite(wPcWrite), .pcWriteCond(wPcWriteCond), .iorD(wIorD), .memRead(wMemRead),
      .memWrite(wMemWrite), .irWrite(wIrWrite), .memToReg(wMemToReg), .regDst(wRegDst),
      .regWrite(wRegWrite), .aluSrcA(wAluSrcA), .aluSrcB(wAluSrcB), .aluOp(wAluOp),
      .pcSrc(wPcSrc), .illegalOp(wIllegalOp), .instrRetired(wCnt), .state(wState)
   );

   // handshake-disabled instance with memReady tied low
   logic        nReset;
   logic [5:0]  nOp;
   logic        nPcWrite, nPcWriteCond, nIorD, nMemRead, nMemWrite, nIrWrite;
   logic        nMemToReg, nRegDst, nRegWrite, nAluSrcA, nIllegalOp;
   logic [1:0]  nAluSrcB, nAluOp, nPcSrc;
   logic [31:0] nCnt;
   logic [3:0]  nState;

   multicycle_control #(.MEM_HANDSHAKE(0)) dutNoHs (
      .clk(clk), .reset(nReset), .opcode(nOp), .memReady(1'b0),
      .pcWrite(nPcWrite), .pcWriteCond(nPcWriteCond), .iorD(nIorD), .memRead(nMemRead),
      .memWrite(nMemWrite), .irWrite(nIrWrite), .memToReg(nMemToReg), .regDst(nRegDst),
      .regWrite(nRegWrite), .aluSrcA(nAluSrcA), .aluSrcB(nAluSrcB), .aluOp(nAluOp),
      .pcSrc(nPcSrc), .illegalOp(nIllegalOp), .instrRetired(nCnt), .state(nState)
   );

   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                      input logic [3:0] st, input logic [16:0] c, input logic [31:0] cnt);
      vec_t v;
      v.rst = rst; v.op = op; v.mr = mr; v.st = st; v.ctl = c; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   initial begin
      int nSeq[5];
      nSeq = '{0, 1, 2, 3, 4};

      reset = 1'b1; memReady = 1'b1; opcode = OPC_LW;
      wReset = 1'b1; wOp = OPC_J;
      nReset = 1'b1; nOp = OPC_LW;

      // reset cycles 2 and 3 (cycle 1 is the initial edge)
      add(1, OPC_LW,  1, 4'd0,  E_ZERO,   0);
      add(1, OPC_LW,  1, 4'd0,  E_ZERO,   0);
      // lw, zero wait states
      add(0, OPC_LW,  1, 4'd0,  E_FETCH,  0);
      add(0, OPC_LW,  1, 4'd1,  E_DEC,    0);
      add(0, OPC_LW,  1, 4'd2,  E_MEMADR, 0);
      add(0, OPC_LW,  1, 4'd3,  E_MEMRD,  0);
      add(0, OPC_LW,  1, 4'd4,  E_MEMWB,  0);
      // sw with two wait states in MEMWR
      add(0, OPC_SW,  1, 4'd0,  E_FETCH,  1);
      add(0, OPC_SW,  1, 4'd1,  E_DEC,    1);
      add(0, OPC_SW,  1, 4'd2,  E_MEMADR, 1);
      add(0, OPC_SW,  0, 4'd5,  E_MEMWR,  1);
      add(0, OPC_SW,  0, 4'd5,  E_MEMWR,  1);
      add(0, OPC_SW,  1, 4'd5,  E_MEMWR,  1);
      // R-type, with one fetch wait state
      add(0, OPC_R,   0, 4'd0,  E_FWAIT,  2);
      add(0, OPC_R,   1, 4'd0,  E_FETCH,  2);
      add(0, OPC_R,   1, 4'd1,  E_DEC,    2);
      add(0, OPC_R,   1, 4'd6,  E_RTEX,   2);
      add(0, OPC_R,   1, 4'd7,  E_RTWB,   2);
      // addi
      add(0, OPC_ADDI,1, 4'd0,  E_FETCH,  3);
      add(0, OPC_ADDI,1, 4'd1,  E_DEC,    3);
      add(0, OPC_ADDI,1, 4'd9,  E_ADDIEX, 3);
      add(0, OPC_ADDI,1, 4'd10, E_ADDIWB, 3);
      // beq
      add(0, OPC_BEQ, 1, 4'd0,  E_FETCH,  4);
      add(0, OPC_BEQ, 1, 4'd1,  E_DEC,    4);
      add(0, OPC_BEQ, 1, 4'd8,  E_BEQ,    4);
      // j
      add(0, OPC_J,   1, 4'd0,  E_FETCH,  5);
      add(0, OPC_J,   1, 4'd1,  E_DEC,    5);
      add(0, OPC_J,   1, 4'd11, E_JEX,    5);
      // illegal opcode: pulse in DECODE, back to FETCH, count unchanged
      add(0, OPC_BAD, 1, 4'd0,  E_FETCH,  6);
      add(0, OPC_BAD, 1, 4'd1,  E_DECILL, 6);
      add(0, OPC_LW,  1, 4'd0,  E_FETCH,  6);
      // lw interrupted by reset while waiting in MEMRD
      add(0, OPC_LW,  1, 4'd1,  E_DEC,    6);
      add(0, OPC_LW,  1, 4'd2,  E_MEMADR, 6);
      add(0, OPC_LW,  0, 4'd3,  E_MEMRD,  6);
      add(1, OPC_LW,  1, 4'd3,  E_ZERO,   6);
      add(0, OPC_LW,  1, 4'd0,  E_FETCH,  0);
      add(0, OPC_LW,  1, 4'd1,  E_DEC,    0);

      @(posedge clk);
      foreach (vecs[i]) begin
         @(negedge clk);
         reset    = vecs[i].rst;
         opcode   = vecs[i].op;
         memReady = vecs[i].mr;
         #1;
         check($sformatf("v%0d.state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("v%0d.ctrl", i), 32'(ctl), 32'(vecs[i].ctl));
         check($sformatf("v%0d.retired", i), instrRetired, vecs[i].cnt);
      end

      // 16 jumps on a 4-bit counter: 15 after 15 instructions, wraps to 0 on the 16th
      @(negedge clk);
      wReset = 1'b0;
      repeat (45) @(posedge clk);
      #1;
      check("wrap.cnt15", 32'(wCnt), 32'd15);
      check("wrap.state15", 32'(wState), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("wrap.cnt0", 32'(wCnt), 32'd0);
      check("wrap.state0", 32'(wState), 32'd0);

      // handshake disabled, memReady tied low: lw still takes 5 cycles
      @(negedge clk);
      nReset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("nohs.state%0d", c), 32'(nState), 32'(nSeq[c]));
         if (c == 0) check("nohs.irWrite", 32'(nIrWrite), 32'd1);
         if (c == 4) check("nohs.regWrite", 32'(nRegWrite), 32'd1);
         @(negedge clk);
      end
      #1;
      check("nohs.endState", 32'(nState), 32'd0);
      check("nohs.retired", nCnt, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control unit for the multi-cycle MIPS datapath, the successor to the single-cycle opcode decoder. It runs a Moore FSM that sequences each instruction over 3–5 cycles and drives the datapath's mux selects and write enables. Memory phases stall on a ready handshake. A retired-instruction counter and an illegal-opcode pulse are provided for debug and performance monitoring.

Parameters:
OP_W, 6, opcode width
MEM_HANDSHAKE, 1, when 1 memory states wait for memReady; when 0 memReady is ignored (treated as 1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  OP_W  instruction[31:26] from instruction register; stable from DECODE until next FETCH completes
memReady  in  1  memory has completed current read/write this cycle
pcWrite  out  1  unconditional PC load
pcWriteCond  out  1  PC load qualified externally by ALU zero
iorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
memRead  out  1  memory read strobe
memWrite  out  1  memory write strobe
irWrite  out  1  instruction register load
memToReg  out  1  1 = MDR to register write data
regDst  out  1  1 = rd, 0 = rt
regWrite  out  1  register file write enable
aluSrcA  out  1  0 = PC, 1 = register A
aluSrcB  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
aluOp  out  2  11 = add, 01 = subtract, 00 = use funct field
pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegalOp  out  1  one-cycle pulse on unsupported opcode
instrRetired  out  CNT_W  count of completed instructions
state  out  4  current FSM state (debug)

Behaviour:
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Reset behaviour:
  - Reset samples on the rising edge of clk. state <= FETCH, instrRetired <= 0.
  - While reset is high, pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite and illegalOp are forced to 0. All other outputs are 0.
  - Reset mid-instruction abandons the instruction; no write enable fires.
- Outputs decode from state only, except for the memReady gating noted below. Unlisted outputs are 0.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=11, pcSrc=00.
  - irWrite=pcWrite=memReady.
  - Stay in FETCH until memReady=1, then go to DECODE.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluOp=11 (branch target precompute).
  - Next state by opcode: lw/sw→MEMADR, R→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX.
  - Any other opcode → FETCH with illegalOp=1 for this cycle. The counter is not incremented.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=11. Next state MEMRD if lw, else MEMWR.
- MEMRD: iorD=1, memRead=1. Hold until memReady, then go to MEMWB.
- MEMWB: regDst=0, memToReg=1, regWrite=1. Next state FETCH; retire.
- MEMWR: iorD=1, memWrite=1. Hold until memReady, then go to FETCH; retire on the exit cycle.
- RTYPEEX: aluSrcA=1, aluSrcB=00, aluOp=00. Next state RTYPEWB.
- RTYPEWB: regDst=1, memToReg=0, regWrite=1. Next state FETCH; retire.
- BEQEX: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, pcWriteCond=1. Next state FETCH; retire.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=11. Next state ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWrite=1. Next state FETCH; retire.
- JEX: pcSrc=10, pcWrite=1. Next state FETCH; retire.
- Cycle counts with zero wait states: lw 5; R-type, sw and addi 4; beq and j 3. Each cycle memReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- instrRetired increments by 1 on the clock edge leaving a retire state. It wraps modulo 2^CNT_W.
- Memory write enables (irWrite/pcWrite in FETCH, memWrite) must not fire more than once per instruction. memWrite stays asserted while waiting; memory commits on memReady.
- State encoding (4 bits): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Unused encodings 12–15 go to FETCH next cycle with all enables 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state_t enum;
  - aluOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - aluSrcB and pcSrc select constants.
- One sub-module, multicycle_ctrl_decode: purely combinational state→control-word decode. The top holds the state register, next-state logic, memReady gating and counter.

Test Plan:
1. Reset held 3 cycles, then released with memReady=1 and opcode=lw → state sequence 0,1,2,3,4,0. regWrite=1 and memToReg=1 only in state 4. instrRetired=1 after 5 cycles.
2. opcode=sw, memReady low for 2 cycles in MEMWR → memWrite high 3 consecutive cycles, then FETCH. No regWrite. instrRetired increments once.
3. Sequence R-type, addi, beq, j with memReady=1 → 4+4+3+3=14 cycles. instrRetired=4. pcWriteCond=1 only in BEQEX. pcSrc=10 and pcWrite=1 in JEX.
4. opcode=111111 → illegalOp pulses exactly 1 cycle in DECODE, state returns to 0, instrRetired unchanged.
5. Reset asserted during MEMRD → all enables 0 that cycle, state=FETCH next cycle, instrRetired=0.
6. CNT_W=4, 16 j instructions → instrRetired wraps to 0. MEM_HANDSHAKE=0 with memReady tied 0 → lw still completes in 5 cycles.
